// File: rtl/ddr4_app_pkg.sv
// Shared state encoding, MIG command codes and line geometry for the DDR4 app adapter.
package ddr4_app_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_CMD,
        RD_WAIT,
        RESP
    } ddr4_adapter_state_e;

    localparam logic [2:0] AppCmdWrite = 3'b000;
    localparam logic [2:0] AppCmdRead  = 3'b001;

    // A 64-byte line holds sixteen 32-bit TL-UL words; address bits [5:2] pick the word.
    localparam int LineBits     = 512;
    localparam int LanesPerLine = LineBits / 32;
    localparam int LaneIdxWidth = $clog2(LanesPerLine);

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types and opcodes used by the DMA main-memory port.
package tlul_pkg;

    // Channel A opcodes
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    // Channel D opcodes
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/ddr4_app_lane_sel.sv
// Word-lane steering between a 32-bit TL-UL word and a MIG line:
// replicates write data, builds the MIG byte mask, and picks the read word.
module ddr4_app_lane_sel
    import ddr4_app_pkg::*;
#(
    parameter int AppDataWidth = 512
) (
    input  logic [31:0]               wdata,
    input  logic [3:0]                wmask,
    input  logic [LaneIdxWidth-1:0]   lane,
    input  logic [AppDataWidth-1:0]   rd_line,
    output logic [AppDataWidth-1:0]   wdf_data,
    output logic [AppDataWidth/8-1:0] wdf_mask,
    output logic [31:0]               rd_word
);

    localparam int Lanes = AppDataWidth / 32;

    // Replicate the word everywhere; only the selected lane is unmasked (MIG mask: 1 = keep).
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        wdf_data = '0;
        wdf_mask = '1;
        for (int i = 0; i < Lanes; i++) begin
            wdf_data[i*32 +: 32] = wdata;
            wdf_mask[i*4 +: 4]   = (int'(lane) == i) ? ~wmask : 4'hF;
        end
        rd_word = rd_line[int'(lane)*32 +: 32];
    end

endmodule

// File: rtl/tlul_ddr4_app_adapter.sv
// TL-UL (32-bit, single outstanding) to Xilinx DDR4 MIG native app interface (512-bit lines).
// Runs entirely in the MIG UI clock domain.
module tlul_ddr4_app_adapter
    import tlul_pkg::*;
    import ddr4_app_pkg::*;
#(
    parameter int AppAddrWidth = 31,
    parameter int AppDataWidth = 512,
    parameter int RdTimeout    = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      calib_done_i,
    input  tl_h2d_t                   tl_i,
    output tl_d2h_t                   tl_o,
    output logic [AppAddrWidth-1:0]   app_addr_o,
    output logic [2:0]                app_cmd_o,
    output logic                      app_en_o,
    input  logic                      app_rdy_i,
    output logic [AppDataWidth-1:0]   app_wdf_data_o,
    output logic [AppDataWidth/8-1:0] app_wdf_mask_o,
    output logic                      app_wdf_wren_o,
    output logic                      app_wdf_end_o,
    input  logic                      app_wdf_rdy_i,
    input  logic [AppDataWidth-1:0]   app_rd_data_i,
    input  logic                      app_rd_data_valid_i
);

    localparam logic [9:0] TimeoutCnt = 10'(RdTimeout);

    ddr4_adapter_state_e state_q;

    logic                    a_ready_q;
    logic                    en_q;
    logic                    wren_q;
    logic                    cmd_done_q;
    logic                    wdf_done_q;
    logic [2:0]              cmd_q;
    logic [AppAddrWidth-1:0] addr_q;
    logic [LaneIdxWidth-1:0] lane_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wmask_q;
    logic [9:0]              cnt_q;

    logic                    d_valid_q;
    logic                    d_error_q;
    logic [2:0]              d_opcode_q;
    logic [31:0]             d_data_q;
    logic [7:0]              d_source_q;
    logic [1:0]              d_size_q;

    logic [AppDataWidth-1:0]   line_data;
    logic [AppDataWidth/8-1:0] line_mask;
    logic [31:0]               rd_word;

    // Byte-offset bits and a_param carry no information for word-wide accesses.
    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[1:0]};

    ddr4_app_lane_sel #(
        .AppDataWidth(AppDataWidth)
    ) u_lane_sel (
        .wdata   (wdata_q),
        .wmask   (wmask_q),
        .lane    (lane_q),
        .rd_line (app_rd_data_i),
        .wdf_data(line_data),
        .wdf_mask(line_mask),
        .rd_word (rd_word)
    );

    // Request accept, MIG command/data handshakes, read wait with timeout, and response hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= IDLE;
            a_ready_q  <= 1'b0;
            en_q       <= 1'b0;
            wren_q     <= 1'b0;
            cmd_done_q <= 1'b0;
            wdf_done_q <= 1'b0;
            cmd_q      <= AppCmdWrite;
            addr_q     <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt_q      <= '0;
            d_valid_q  <= 1'b0;
            d_error_q  <= 1'b0;
            d_opcode_q <= AccessAck;
            d_data_q   <= '0;
            d_source_q <= '0;
            d_size_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tl_i.a_valid && a_ready_q) begin
                        a_ready_q  <= 1'b0;
                        addr_q     <= AppAddrWidth'({tl_i.a_address[31:6], 3'b000});
                        lane_q     <= tl_i.a_address[5:2];
                        wdata_q    <= tl_i.a_data;
                        wmask_q    <= tl_i.a_mask;
                        d_source_q <= tl_i.a_source;
                        d_size_q   <= tl_i.a_size;
                        d_error_q  <= 1'b0;
                        d_data_q   <= '0;
                        case (tl_i.a_opcode)
                            Get: begin
                                state_q <= RD_CMD;
                                cmd_q   <= AppCmdRead;
                                en_q    <= 1'b1;
                            end
                            PutFullData, PutPartialData: begin
                                state_q    <= WR;
                                cmd_q      <= AppCmdWrite;
                                en_q       <= 1'b1;
                                wren_q     <= 1'b1;
                                cmd_done_q <= 1'b0;
                                wdf_done_q <= 1'b0;
                            end
                            default: begin
                                // Unsupported opcode: answer with an error, never touch DDR.
                                state_q    <= RESP;
                                d_valid_q  <= 1'b1;
                                d_opcode_q <= AccessAck;
                                d_error_q  <= 1'b1;
                            end
                        endcase
                    end else begin
                        a_ready_q <= calib_done_i;
                    end
                end
                WR: begin
                    if (en_q && app_rdy_i) begin
                        en_q       <= 1'b0;
                        cmd_done_q <= 1'b1;
                    end
                    if (wren_q && app_wdf_rdy_i) begin
                        wren_q     <= 1'b0;
                        wdf_done_q <= 1'b1;
                    end
                    if (cmd_done_q && wdf_done_q) begin
                        state_q    <= RESP;
                        d_valid_q  <= 1'b1;
                        d_opcode_q <= AccessAck;
                    end
                end
                RD_CMD: begin
                    if (app_rdy_i) begin
                        en_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (app_rd_data_valid_i) begin
                        state_q    <= RESP;
                        d_valid_q  <= 1'b1;
                        d_opcode_q <= AccessAckData;
                        d_data_q   <= rd_word;
                        d_error_q  <= 1'b0;
                    end else if (cnt_q == TimeoutCnt) begin
                        state_q    <= RESP;
                        d_valid_q  <= 1'b1;
                        d_opcode_q <= AccessAckData;
                        d_data_q   <= '0;
                        d_error_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                RESP: begin
                    if (tl_i.d_ready) begin
                        d_valid_q <= 1'b0;
                        state_q   <= IDLE;
                        a_ready_q <= calib_done_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Drive the TL-UL response channel from the held response registers.
    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
        tl_o.a_ready  = a_ready_q;
    end

    assign app_addr_o     = addr_q;
    assign app_cmd_o      = cmd_q;
    assign app_en_o       = en_q;
    assign app_wdf_data_o = line_data;
    assign app_wdf_mask_o = (state_q == WR) ? line_mask : '0;
    assign app_wdf_wren_o = wren_q;
    assign app_wdf_end_o  = wren_q;

endmodule

// File: tb/tb_tlul_ddr4_app_adapter.sv
// Scoreboard bench for the TL-UL to DDR4 MIG app adapter: directed tests push expected
// MIG commands, write lines and TL-UL responses; a monitor pops and compares on handshakes.
module tb_tlul_ddr4_app_adapter;
    import tlul_pkg::*;
    import ddr4_app_pkg::*;

    localparam int AW = 31;
    localparam int DW = 512;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          calib_done_i;
    tl_h2d_t       tl_i;
    tl_d2h_t       tl_o;
    logic [AW-1:0] app_addr_o;
    logic [2:0]    app_cmd_o;
    logic          app_en_o;
    logic          app_rdy_i;
    logic [DW-1:0] app_wdf_data_o;
    logic [MW-1:0] app_wdf_mask_o;
    logic          app_wdf_wren_o;
    logic          app_wdf_end_o;
    logic          app_wdf_rdy_i;
    logic [DW-1:0] app_rd_data_i;
    logic          app_rd_data_valid_i;

    tlul_ddr4_app_adapter dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .calib_done_i       (calib_done_i),
        .tl_i               (tl_i),
        .tl_o               (tl_o),
        .app_addr_o         (app_addr_o),
        .app_cmd_o          (app_cmd_o),
        .app_en_o           (app_en_o),
        .app_rdy_i          (app_rdy_i),
        .app_wdf_data_o     (app_wdf_data_o),
        .app_wdf_mask_o     (app_wdf_mask_o),
        .app_wdf_wren_o     (app_wdf_wren_o),
        .app_wdf_end_o      (app_wdf_end_o),
        .app_wdf_rdy_i      (app_wdf_rdy_i),
        .app_rd_data_i      (app_rd_data_i),
        .app_rd_data_valid_i(app_rd_data_valid_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  opcode;
        logic        err;
        logic [31:0] data;
        logic [7:0]  source;
        logic [1:0]  size;
    } exp_d_t;

    typedef struct {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
    } exp_cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } exp_wdf_t;

    exp_d_t   exp_d_q[$];
    exp_cmd_t exp_cmd_q[$];
    exp_wdf_t exp_wdf_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Monitor: compare every handshake against the oldest expectation.
    exp_d_t   md;
    exp_cmd_t mc;
    exp_wdf_t mw;
    always @(negedge clk) begin
        if (!rst_i) begin
            if (tl_o.d_valid && tl_i.d_ready) begin
                if (exp_d_q.size() == 0) begin
                    check("d_unexpected", 1, 0);
                end else begin
                    md = exp_d_q.pop_front();
                    check("d_opcode", tl_o.d_opcode, md.opcode);
                    check("d_error", tl_o.d_error, md.err);
                    check("d_data", tl_o.d_data, md.data);
                    check("d_source", tl_o.d_source, md.source);
                    check("d_size", tl_o.d_size, md.size);
                end
            end
            if (app_en_o && app_rdy_i) begin
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    mc = exp_cmd_q.pop_front();
                    check("app_cmd", app_cmd_o, mc.cmd);
                    check("app_addr", app_addr_o, mc.addr);
                end
            end
            if (app_wdf_wren_o && app_wdf_rdy_i) begin
                if (exp_wdf_q.size() == 0) begin
                    check("wdf_unexpected", 1, 0);
                end else begin
                    mw = exp_wdf_q.pop_front();
                    check("wdf_data", app_wdf_data_o, mw.data);
                    check("wdf_mask", app_wdf_mask_o, mw.mask);
                    check("wdf_end", app_wdf_end_o, 1);
                end
            end
        end
    end

    // Present one A beat and hold it until accepted (bounded).
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src, input logic [1:0] size);
        bit ok = 1'b0;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
        tl_i.a_size    = size;
        tl_i.a_valid   = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (tl_o.a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("a_accept_timeout", 0, 1);
        else @(posedge clk);
        #1 tl_i.a_valid = 1'b0;
    endtask

    // Wait (bounded) for the MIG command handshake; returns on the accepting edge.
    task automatic wait_cmd();
        bit ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (app_en_o && app_rdy_i) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_timeout", 0, 1);
        @(posedge clk);
    endtask

    // Return one read beat 'delay' cycles after the command was accepted.
    task automatic mig_beat(input logic [DW-1:0] line, input int delay);
        repeat (delay - 1) @(posedge clk);
        #1;
        app_rd_data_i       = line;
        app_rd_data_valid_i = 1'b1;
        @(posedge clk);
        #1 app_rd_data_valid_i = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been seen.
    task automatic wait_idle(input int bound);
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (exp_d_q.size() == 0) break;
        end
        if (exp_d_q.size() != 0) begin
            check("resp_timeout", exp_d_q.size(), 0);
            exp_d_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] line;

    initial begin
        tl_i                = '0;
        tl_i.d_ready        = 1'b1;
        rst_i               = 1'b1;
        calib_done_i        = 1'b1;
        app_rdy_i           = 1'b1;
        app_wdf_rdy_i       = 1'b1;
        app_rd_data_i       = '0;
        app_rd_data_valid_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", tl_o.a_ready, 0);
        check("rst_d_valid", tl_o.d_valid, 0);
        check("rst_app_en", app_en_o, 0);
        check("rst_wren", app_wdf_wren_o, 0);
        check("rst_cmd", app_cmd_o, 0);
        check("rst_mask", app_wdf_mask_o, 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk);
        #1;

        // 1. PutFull 0x48: lane 2, line address 0x8, ack two cycles after accept
        exp_cmd_q.push_back('{AppCmdWrite, 31'h8});
        exp_wdf_q.push_back('{{16{32'hDEADBEEF}}, 64'hFFFF_FFFF_FFFF_F0FF});
        exp_d_q.push_back('{AccessAck, 1'b0, 32'h0, 8'h03, 2'd2});
        issue(PutFullData, 32'h0000_0048, 4'hF, 32'hDEADBEEF, 8'h03, 2'd2);
        @(negedge clk);
        check("wr_lat0", tl_o.d_valid, 0);
        @(negedge clk);
        check("wr_lat1", tl_o.d_valid, 0);
        @(negedge clk);
        check("wr_lat2", tl_o.d_valid, 1);
        wait_idle(20);

        // 2. Get 0x7C: lane 15, line address 0x8, beat 3 cycles after command
        for (int i = 0; i < 16; i++) line[i*32 +: 32] = 32'h1000_0000 + i;
        line[480 +: 32] = 32'h1234_5678;
        exp_cmd_q.push_back('{AppCmdRead, 31'h8});
        exp_d_q.push_back('{AccessAckData, 1'b0, 32'h1234_5678, 8'h2A, 2'd2});
        issue(Get, 32'h0000_007C, 4'hF, 32'h0, 8'h2A, 2'd2);
        wait_cmd();
        mig_beat(line, 3);
        wait_idle(20);

        // 3a. Write data accepted first, command 4 cycles later
        app_rdy_i = 1'b0;
        exp_cmd_q.push_back('{AppCmdWrite, 31'h200});
        exp_wdf_q.push_back('{{16{32'h1111_2222}}, 64'hFFFF_FFFF_FFFF_FFF0});
        exp_d_q.push_back('{AccessAck, 1'b0, 32'h0, 8'h01, 2'd2});
        issue(PutFullData, 32'h0000_1000, 4'hF, 32'h1111_2222, 8'h01, 2'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("skew_en_held", app_en_o, 1);
        end
        @(posedge clk);
        #1 app_rdy_i = 1'b1;
        wait_idle(20);

        // 3b. Command accepted first, write data 4 cycles later (PutPartial, lane 15, byte 3)
        app_wdf_rdy_i = 1'b0;
        exp_cmd_q.push_back('{AppCmdWrite, 31'h0});
        exp_wdf_q.push_back('{{16{32'h55AA_55AA}}, 64'h7FFF_FFFF_FFFF_FFFF});
        exp_d_q.push_back('{AccessAck, 1'b0, 32'h0, 8'h02, 2'd0});
        issue(PutPartialData, 32'h0000_003C, 4'h8, 32'h55AA_55AA, 8'h02, 2'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("skew_wren_held", app_wdf_wren_o, 1);
        end
        @(posedge clk);
        #1 app_wdf_rdy_i = 1'b1;
        wait_idle(20);

        // 4a. Response backpressure: d_* hold and a_ready stays low
        tl_i.d_ready = 1'b0;
        exp_cmd_q.push_back('{AppCmdWrite, 31'h20});
        exp_wdf_q.push_back('{{16{32'hCAFE_F00D}}, 64'hFFFF_FFFF_FFFF_FFCF});
        exp_d_q.push_back('{AccessAck, 1'b0, 32'h0, 8'h05, 2'd1});
        issue(PutPartialData, 32'h0000_0104, 4'h3, 32'hCAFE_F00D, 8'h05, 2'd1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tl_o.d_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_d_valid", tl_o.d_valid, 1);
            check("bp_d_source", tl_o.d_source, 8'h05);
            check("bp_d_error", tl_o.d_error, 0);
            check("bp_a_ready", tl_o.a_ready, 0);
        end
        @(posedge clk);
        #1 tl_i.d_ready = 1'b1;
        wait_idle(20);

        // 4b. Calibration low: a_ready stays low, no command issued
        calib_done_i = 1'b0;
        @(posedge clk);
        #1;
        tl_i.a_opcode  = Get;
        tl_i.a_address = 32'h0000_0040;
        tl_i.a_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("calib_a_ready", tl_o.a_ready, 0);
        end
        @(posedge clk);
        #1;
        tl_i.a_valid = 1'b0;
        calib_done_i = 1'b1;
        @(posedge clk);
        #1;

        // 5a. Read timeout: no beat ever arrives
        exp_cmd_q.push_back('{AppCmdRead, 31'h10});
        exp_d_q.push_back('{AccessAckData, 1'b1, 32'h0, 8'h09, 2'd2});
        issue(Get, 32'h0000_0080, 4'hF, 32'h0, 8'h09, 2'd2);
        wait_idle(1200);

        // 5b. Unsupported opcode: error response, no MIG command
        exp_d_q.push_back('{AccessAck, 1'b1, 32'h0, 8'h04, 2'd2});
        issue(3'b010, 32'h0000_0040, 4'hF, 32'h0, 8'h04, 2'd2);
        @(negedge clk);
        check("badop_no_en", app_en_o, 0);
        wait_idle(20);

        // 6. Reset while waiting for the read beat, then a stale beat, then a clean read
        exp_cmd_q.push_back('{AppCmdRead, 31'h8});
        issue(Get, 32'h0000_0040, 4'hF, 32'h0, 8'h06, 2'd2);
        wait_cmd();
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("mid_rst_d_valid", tl_o.d_valid, 0);
        check("mid_rst_app_en", app_en_o, 0);
        check("mid_rst_wren", app_wdf_wren_o, 0);
        check("mid_rst_cmd", app_cmd_o, 0);
        check("mid_rst_mask", app_wdf_mask_o, 0);
        check("mid_rst_a_ready", tl_o.a_ready, 0);
        line = '0;
        line[31:0] = 32'hBAD0_BAD0;
        @(posedge clk);
        mig_beat(line, 1);
        repeat (3) @(negedge clk);
        check("stale_ignored", tl_o.d_valid, 0);
        @(posedge clk);
        #1;
        line[31:0] = 32'hA5A5_0001;
        exp_cmd_q.push_back('{AppCmdRead, 31'h8});
        exp_d_q.push_back('{AccessAckData, 1'b0, 32'hA5A5_0001, 8'h07, 2'd2});
        issue(Get, 32'h0000_0040, 4'hF, 32'h0, 8'h07, 2'd2);
        wait_cmd();
        mig_beat(line, 2);
        wait_idle(20);

        check("cmd_q_empty", exp_cmd_q.size(), 0);
        check("wdf_q_empty", exp_wdf_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
